aes_cbc_engine: RTL and testbench
=================================

Name: aes_cbc_engine

Overview:
- Streaming AES-128 encryption datapath for the HWPE accelerator, operating in CBC mode.
- Consumes 32-bit plaintext words on one stream and 32-bit key words on a second stream.
- Encrypts each 128-bit block iteratively, one round per cycle, and emits 32-bit ciphertext words on an output stream.
- Sits between the streamer (source/sink) and the controller (ctrl/flags).

Parameters:
- IV, 128'h000102030405060708090a0b0c0d0e0f, initial CBC chaining value after reset/clear.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  synchronous active-low reset.
- a_i  input  hwpe_stream_intf_stream sink, DATA_WIDTH 32  plaintext words.
- b_i  input  hwpe_stream_intf_stream sink, DATA_WIDTH 32  key words.
- d_o  output  hwpe_stream_intf_stream source, DATA_WIDTH 32  ciphertext words (strb = 4'hF).
- ctrl_i  input  ctrl_engine_t  {clear, enable}.
- flags_o  output  flags_engine_t  {busy, done}.

Behaviour:
- Transfer occurs when valid && ready at the clk_i edge. Once d_o.valid is asserted, it and d_o.data stay stable until the transfer.
- Word order is big-endian: word 0 = block bits [127:96] = bytes 0..3, with byte 0 in the word MSB.
- FSM states: LOAD, CALC, OUT.
- LOAD:
  - a_i.ready = 1 while the plaintext count < 4; b_i.ready = 1 while the key count < 4. The two streams are accepted independently, in any interleaving.
  - When both counts reach 4: state <= (plaintext XOR chain) XOR key, round = 1, go to CALC.
- CALC: one full AES round per cycle.
  - Round key is derived on the fly from the previous round key (RotWord/SubWord/Rcon).
  - Rounds 1..9: SubBytes, ShiftRows, MixColumns, AddRoundKey. Round 10 omits MixColumns.
  - After round 10, go to OUT.
  - Latency: first d_o.valid occurs 11 cycles after the cycle in which the 8th input word is accepted.
- OUT:
  - Present ciphertext words 0..3 in order, each on handshake.
  - On the 4th transfer: chain <= ciphertext, counts cleared, done pulses for 1 cycle, go to LOAD.
- A new key must be supplied for every block; there is no key retention.
- Inputs are never ready outside LOAD.
- busy = 1 in CALC and OUT.
- ctrl_i.enable = 0:
  - all a_i/b_i ready forced to 0; CALC does not advance.
  - d_o.valid, if already asserted, holds, and a handshake in OUT still completes.
- ctrl_i.clear = 1 (synchronous): same effect as reset, overrides everything that cycle.
- Reset/clear values:
  - state LOAD, counts 0, chain = IV.
  - d_o.valid = 0, d_o.data = 0, a_i.ready = 0 during reset (1 the following cycle), b_i.ready likewise.
  - busy = 0, done = 0.
- Reset mid-block discards all partial input and output.
- Back-pressure: d_o.ready may toggle arbitrarily; no word is lost or duplicated.

Optional Feature:
- Macro AES_CBC_ENGINE_CBC_EN.
- Defined (default build): CBC chaining as above.
- Undefined: ECB. The chain register and IV parameter are removed, and the plaintext XOR chain step is skipped.

Decomposition:
- Package aes_package:
  - ctrl_engine_t {logic clear; logic enable;}
  - flags_engine_t {logic busy; logic done;}
  - state enum
  - Rcon constant table
  - default IV constant
- Sub-module aes_sbox: combinational 8-bit forward S-box, 20 instances (16 state bytes + 4 key-schedule bytes).

Test Plan:
- CBC block 1: key 2b7e1516 28aed2a6 abf71588 09cf4f3c, plaintext 6bc1bee2 2e409f96 e93d7e11 7393172a -> 7649abac 8119b246 cee98e9b 12e9197d, done pulses once.
- CBC chain of 4 blocks (same key each block; plaintexts ae2d8a57 1e03ac9c 9eb76fac 45af8e51 / 30c81c46 a35ce411 e5fbc119 1a0a52ef / f69f2445 df4f9b17 ad2b417b e66c3710) -> 5086cb9b 507219ee 95db113a 917678b2 / 73bed6b8 e3c1743b 7116e69e 22229516 / 3ff1caa1 681fac09 120eca30 7586e1a7.
- d_o.ready toggling pseudo-randomly during the 4-block run -> identical 16 words, each transferred exactly once, data stable while stalled.
- Key words delayed 1 cycle behind plaintext words, or all key words first -> same results. First output valid exactly 11 cycles after the last input accept.
- clear asserted after block 1 -> next block with block-1 plaintext yields 7649abac... again (chain reset to IV). Reset mid-CALC -> no output, busy = 0.
- ECB build (macro undefined), block-1 inputs -> 3ad77bb4 0d7a3660 a89ecaf3 2466ef97.

Source files
------------

// File: rtl/aes_package.sv
// Shared types and constants for the AES-128 streaming engine.
// Consumed by aes_cbc_engine (top) and aes_sbox.
package aes_package;

  typedef struct packed {
    logic clear;
    logic enable;
  } ctrl_engine_t;

  typedef struct packed {
    logic busy;
    logic done;
  } flags_engine_t;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } aes_state_e;

  // Round constants for rounds 1..10, round 1 in the MSB byte.
  localparam logic [79:0] AES_RCON = 80'h01_02_04_08_10_20_40_80_1b_36;

  // Chaining value after reset/clear when CBC chaining is built in.
  localparam logic [127:0] AES_IV_DEFAULT = 128'h000102030405060708090a0b0c0d0e0f;

  localparam logic [3:0] AES_LAST_ROUND = 4'd10;

  function automatic logic [7:0] aes_rcon(input logic [3:0] round);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 1; i <= 10; i++) begin
      if (round == 4'(i)) r = AES_RCON[(10 - i) * 8 +: 8];
    end
    return r;
  endfunction

  // Multiply by x in GF(2^8) modulo the AES polynomial.
  function automatic logic [7:0] aes_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // MixColumns on one column; byte 0 (row 0) is the MSB.
  function automatic logic [31:0] aes_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] r0, r1, r2, r3;
    {a0, a1, a2, a3} = col;
    r0 = aes_xtime(a0) ^ aes_xtime(a1) ^ a1 ^ a2 ^ a3;
    r1 = a0 ^ aes_xtime(a1) ^ aes_xtime(a2) ^ a2 ^ a3;
    r2 = a0 ^ a1 ^ aes_xtime(a2) ^ aes_xtime(a3) ^ a3;
    r3 = aes_xtime(a0) ^ a0 ^ a1 ^ a2 ^ aes_xtime(a3);
    return {r0, r1, r2, r3};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] s
);

  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the top byte of the table, so index from the MSB end.
  assign s = SBOX_TABLE[{~x, 3'b000} +: 8];

endmodule

// File: rtl/aes_cbc_engine.sv
// Streaming AES-128 encryption engine, one round per cycle.
// Plaintext on a_i, key on b_i (new key every block), ciphertext on d_o.
// Build option AES_CBC_ENGINE_CBC_EN: when defined, CBC chaining with IV;
// when undefined, plain ECB (no chain register, no IV parameter).
//
// state | meaning
// ------+-----------------------------------------------------------
// LOAD  | collect 4 plaintext + 4 key words, fold in chain and key
// CALC  | one AES round per enabled cycle, rounds 1..10
// OUT   | present ciphertext words 0..3, update chain on the last
module aes_cbc_engine
  import aes_package::*;
`ifdef AES_CBC_ENGINE_CBC_EN
#(
  parameter logic [127:0] IV = AES_IV_DEFAULT
)
`endif
(
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          a_i_valid,
  output logic          a_i_ready,
  input  logic [31:0]   a_i_data,
  input  logic          b_i_valid,
  output logic          b_i_ready,
  input  logic [31:0]   b_i_data,
  output logic          d_o_valid,
  input  logic          d_o_ready,
  output logic [31:0]   d_o_data,
  output logic [3:0]    d_o_strb,
  input  ctrl_engine_t  ctrl_i,
  output flags_engine_t flags_o
);

  aes_state_e   fsm_q, fsm_d;

  // state_q doubles as the plaintext shift buffer while in LOAD and holds
  // the ciphertext while in OUT; key_q likewise collects the key words.
  logic [127:0] state_q;
  logic [127:0] key_q;
  logic [2:0]   a_cnt_q, b_cnt_q;
  logic [2:0]   a_cnt_nxt, b_cnt_nxt;
  logic [3:0]   round_q;
  logic [1:0]   out_cnt_q;
  logic         done_q;
`ifdef AES_CBC_ENGINE_CBC_EN
  logic [127:0] chain_q;
`endif

  logic         soft_rst;
  logic         a_acc, b_acc;
  logic         blk_ready;
  logic         d_xfer;
  logic [127:0] pt_full, key_full, blk_in;

  logic [127:0] sb_flat, sr_flat, mc_flat;
  logic [127:0] key_nxt, round_out;
  logic [31:0]  kw0, kw1, kw2, kw3;
  logic [31:0]  rot_w, sub_w;
  logic [31:0]  nk0, nk1, nk2, nk3;
  logic [31:0]  out_word;

  assign soft_rst = !rst_ni || ctrl_i.clear;

  assign a_i_ready = !soft_rst && ctrl_i.enable && (fsm_q == LOAD) && (a_cnt_q != 3'd4);
  assign b_i_ready = !soft_rst && ctrl_i.enable && (fsm_q == LOAD) && (b_cnt_q != 3'd4);
  assign a_acc     = a_i_valid && a_i_ready;
  assign b_acc     = b_i_valid && b_i_ready;
  assign a_cnt_nxt = a_cnt_q + {2'b00, a_acc};
  assign b_cnt_nxt = b_cnt_q + {2'b00, b_acc};

  // Start the block on the very edge that accepts the last word so the
  // first output lands 11 cycles later.
  assign blk_ready = (fsm_q == LOAD) && (a_cnt_nxt == 3'd4) && (b_cnt_nxt == 3'd4);

  assign pt_full  = a_acc ? {state_q[95:0], a_i_data} : state_q;
  assign key_full = b_acc ? {key_q[95:0], b_i_data} : key_q;
`ifdef AES_CBC_ENGINE_CBC_EN
  assign blk_in   = pt_full ^ chain_q ^ key_full;
`else
  assign blk_in   = pt_full ^ key_full;
`endif

  assign d_xfer   = (fsm_q == OUT) && d_o_ready;
  assign d_o_strb = 4'hF;

  // SubBytes on all 16 state bytes.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .x (state_q[(15 - i) * 8 +: 8]),
      .s (sb_flat[(15 - i) * 8 +: 8])
    );
  end

  // ShiftRows: byte (row r, col c) takes the byte from column (c + r) mod 4.
  for (genvar i = 0; i < 16; i++) begin : g_shift
    localparam int C   = i / 4;
    localparam int R   = i % 4;
    localparam int SRC = 4 * ((C + R) % 4) + R;
    assign sr_flat[(15 - i) * 8 +: 8] = sb_flat[(15 - SRC) * 8 +: 8];
  end

  for (genvar c = 0; c < 4; c++) begin : g_mix
    assign mc_flat[(3 - c) * 32 +: 32] = aes_mix_col(sr_flat[(3 - c) * 32 +: 32]);
  end

  // Key schedule step from the previous round key.
  assign {kw0, kw1, kw2, kw3} = key_q;
  assign rot_w = {kw3[23:0], kw3[31:24]};

  for (genvar j = 0; j < 4; j++) begin : g_ksbox
    aes_sbox u_ksbox (
      .x (rot_w[(3 - j) * 8 +: 8]),
      .s (sub_w[(3 - j) * 8 +: 8])
    );
  end

  assign nk0     = kw0 ^ sub_w ^ {aes_rcon(round_q), 24'h000000};
  assign nk1     = kw1 ^ nk0;
  assign nk2     = kw2 ^ nk1;
  assign nk3     = kw3 ^ nk2;
  assign key_nxt = {nk0, nk1, nk2, nk3};

  // The final round skips MixColumns.
  assign round_out = ((round_q == AES_LAST_ROUND) ? sr_flat : mc_flat) ^ key_nxt;

  // Select the ciphertext word for the current output slot.
  always_comb begin
    out_word = state_q[127:96];
    case (out_cnt_q)
      2'd0:    out_word = state_q[127:96];
      2'd1:    out_word = state_q[95:64];
      2'd2:    out_word = state_q[63:32];
      default: out_word = state_q[31:0];
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (soft_rst) fsm_q <= LOAD;
    else          fsm_q <= fsm_d;
  end

  // Next-state decode and stream/flag outputs.
  always_comb begin
    fsm_d        = fsm_q;
    d_o_valid    = 1'b0;
    d_o_data     = 32'h0;
    flags_o      = '0;
    case (fsm_q)
      LOAD: begin
        if (blk_ready) fsm_d = CALC;
      end
      CALC: begin
        if (ctrl_i.enable && (round_q == AES_LAST_ROUND)) fsm_d = OUT;
      end
      OUT: begin
        d_o_valid = 1'b1;
        d_o_data  = out_word;
        if (d_xfer && (out_cnt_q == 2'd3)) fsm_d = LOAD;
      end
      default: fsm_d = LOAD;
    endcase
    flags_o.busy = (fsm_q != LOAD);
    flags_o.done = done_q;
  end

  // Datapath: input collection, round iteration, output sequencing.
  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      state_q   <= '0;
      key_q     <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
      round_q   <= '0;
      out_cnt_q <= '0;
      done_q    <= 1'b0;
`ifdef AES_CBC_ENGINE_CBC_EN
      chain_q   <= IV;
`endif
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        LOAD: begin
          a_cnt_q   <= a_cnt_nxt;
          b_cnt_q   <= b_cnt_nxt;
          key_q     <= key_full;
          out_cnt_q <= '0;
          if (blk_ready) begin
            state_q <= blk_in;
            round_q <= 4'd1;
          end else begin
            state_q <= pt_full;
          end
        end
        CALC: begin
          if (ctrl_i.enable) begin
            state_q <= round_out;
            key_q   <= key_nxt;
            round_q <= round_q + 4'd1;
          end
        end
        OUT: begin
          if (d_xfer) begin
            out_cnt_q <= out_cnt_q + 2'd1;
            if (out_cnt_q == 2'd3) begin
              a_cnt_q <= '0;
              b_cnt_q <= '0;
              done_q  <= 1'b1;
`ifdef AES_CBC_ENGINE_CBC_EN
              chain_q <= state_q;
`endif
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cbc_engine.sv
// Directed testbench for aes_cbc_engine using FIPS-197 / SP800-38A vectors.
// Expected ciphertexts follow the AES_CBC_ENGINE_CBC_EN build option.
module tb_aes_cbc_engine;
  import aes_package::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, a_ready;
  logic [31:0]   a_data;
  logic          b_valid, b_ready;
  logic [31:0]   b_data;
  logic          d_valid, d_ready;
  logic [31:0]   d_data;
  logic [3:0]    d_strb;
  ctrl_engine_t  ctrl;
  flags_engine_t flags;

  int n_checks = 0;
  int n_fail   = 0;

  logic [127:0] key_v;
  logic [127:0] pt_v  [4];
  logic [127:0] exp_v [4];

  always #5 clk = ~clk;

  aes_cbc_engine dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .a_i_valid (a_valid),
    .a_i_ready (a_ready),
    .a_i_data  (a_data),
    .b_i_valid (b_valid),
    .b_i_ready (b_ready),
    .b_i_data  (b_data),
    .d_o_valid (d_valid),
    .d_o_ready (d_ready),
    .d_o_data  (d_data),
    .d_o_strb  (d_strb),
    .ctrl_i    (ctrl),
    .flags_o   (flags)
  );

  // mode 0: both streams together; 1: key one cycle behind plaintext;
  // 2: all key words first; 3: enable dropped for 5 cycles during CALC.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] key,
                           input int mode, input bit rnd_ready,
                           output logic [127:0] ct, output int lat,
                           output int dones, output int stalls,
                           output bit timeout, output bit tail_valid);
    int pi, ki, oi, last_acc, first_valid;
    bit a_fire, b_fire, d_fire, pv, pr;
    logic [31:0] pd;
    pi = 0; ki = 0; oi = 0; last_acc = -1; first_valid = -1;
    dones = 0; stalls = 0; ct = '0; pv = 0; pr = 0; pd = '0;
    for (int cyc = 0; cyc < 300 && oi < 4; cyc++) begin
      @(negedge clk);
      a_valid = (pi < 4) && (mode != 2 || ki == 4);
      a_data  = (pi < 4) ? pt[(3 - pi) * 32 +: 32] : 32'h0;
      b_valid = (ki < 4) && (mode != 1 || ki < pi);
      b_data  = (ki < 4) ? key[(3 - ki) * 32 +: 32] : 32'h0;
      ctrl.enable = !(mode == 3 && last_acc >= 0 && cyc >= last_acc + 2 && cyc < last_acc + 7);
      d_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
      d_fire = d_valid && d_ready;
      if (flags.done) dones++;
      if (d_valid && first_valid < 0) first_valid = cyc;
      if (pv && !pr && (!d_valid || d_data !== pd)) stalls++;
      pv = d_valid; pr = d_ready; pd = d_data;
      if (d_fire) ct[(3 - oi) * 32 +: 32] = d_data;
      @(posedge clk);
      if (a_fire) pi++;
      if (b_fire) ki++;
      if (d_fire) oi++;
      if (pi == 4 && ki == 4 && last_acc < 0) last_acc = cyc;
    end
    timeout = (oi < 4);
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; ctrl.enable = 1'b1; d_ready = 1'b1;
    #1;
    if (flags.done) dones++;
    tail_valid = d_valid;
    lat = (first_valid >= 0 && last_acc >= 0) ? first_valid - last_acc : -1;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    ctrl.clear = 1'b1;
    #1;
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0 || flags.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_ready: got a=%b b=%b busy=%b expected 0 0 0", a_ready, b_ready, flags.busy);
    end
    @(negedge clk);
    ctrl.clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ctrl.clear = 1'b0; ctrl.enable = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; a_data = '0; b_data = '0; d_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_a_ready: got %b expected 0", a_ready); end
    n_checks++;
    if (b_ready !== 1'b0) begin n_fail++; $display("FAIL rst_b_ready: got %b expected 0", b_ready); end
    n_checks++;
    if (d_valid !== 1'b0 || d_data !== 32'h0) begin
      n_fail++; $display("FAIL rst_d: got valid=%b data=%h expected 0 00000000", d_valid, d_data);
    end
    n_checks++;
    if (flags.busy !== 1'b0 || flags.done !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags: got busy=%b done=%b expected 0 0", flags.busy, flags.done);
    end
    n_checks++;
    if (d_strb !== 4'hF) begin n_fail++; $display("FAIL rst_strb: got %h expected f", d_strb); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      n_fail++; $display("FAIL post_rst_ready: got a=%b b=%b expected 1 1", a_ready, b_ready);
    end
  endtask

  task automatic test_cbc_block1();
    logic [127:0] ct; int lat, dn, st; bit to, tv;
    run_block(pt_v[0], key_v, 0, 1'b0, ct, lat, dn, st, to, tv);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL block1_timeout: got timeout expected 4 words"); end
    n_checks++;
    if (ct !== exp_v[0]) begin n_fail++; $display("FAIL block1_ct: got %h expected %h", ct, exp_v[0]); end
    n_checks++;
    if (dn !== 1) begin n_fail++; $display("FAIL block1_done: got %0d pulses expected 1", dn); end
    n_checks++;
    if (lat !== 11) begin n_fail++; $display("FAIL block1_latency: got %0d expected 11", lat); end
    n_checks++;
    if (tv !== 1'b0 || flags.busy !== 1'b0) begin
      n_fail++; $display("FAIL block1_tail: got valid=%b busy=%b expected 0 0", tv, flags.busy);
    end
  endtask

  task automatic test_chain();
    logic [127:0] ct; int lat, dn, st; bit to, tv;
    for (int b = 1; b < 4; b++) begin
      run_block(pt_v[b], key_v, 0, 1'b0, ct, lat, dn, st, to, tv);
      n_checks++;
      if (ct !== exp_v[b] || to) begin
        n_fail++; $display("FAIL chain_ct%0d: got %h expected %h", b, ct, exp_v[b]);
      end
      n_checks++;
      if (dn !== 1) begin n_fail++; $display("FAIL chain_done%0d: got %0d expected 1", b, dn); end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] ct; int lat, dn, st, st_tot; bit to, tv;
    st_tot = 0;
    pulse_clear();
    for (int b = 0; b < 4; b++) begin
      run_block(pt_v[b], key_v, 0, 1'b1, ct, lat, dn, st, to, tv);
      st_tot += st;
      n_checks++;
      if (ct !== exp_v[b] || to) begin
        n_fail++; $display("FAIL bp_ct%0d: got %h expected %h", b, ct, exp_v[b]);
      end
      n_checks++;
      if (dn !== 1 || tv !== 1'b0) begin
        n_fail++; $display("FAIL bp_once%0d: got done=%0d tail_valid=%b expected 1 0", b, dn, tv);
      end
    end
    n_checks++;
    if (st_tot !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", st_tot); end
  endtask

  task automatic test_input_order();
    logic [127:0] ct; int lat, dn, st; bit to, tv;
    for (int m = 1; m <= 2; m++) begin
      pulse_clear();
      run_block(pt_v[0], key_v, m, 1'b0, ct, lat, dn, st, to, tv);
      n_checks++;
      if (ct !== exp_v[0] || to) begin
        n_fail++; $display("FAIL order%0d_ct: got %h expected %h", m, ct, exp_v[0]);
      end
      n_checks++;
      if (lat !== 11) begin n_fail++; $display("FAIL order%0d_latency: got %0d expected 11", m, lat); end
    end
  endtask

  task automatic test_enable();
    logic [127:0] ct; int lat, dn, st; bit to, tv;
    pulse_clear();
    @(negedge clk);
    ctrl.enable = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_data = pt_v[0][127:96]; b_data = key_v[127:96];
    #1;
    n_checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      n_fail++; $display("FAIL enable_ready: got a=%b b=%b expected 0 0", a_ready, b_ready);
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; ctrl.enable = 1'b1;
    run_block(pt_v[0], key_v, 3, 1'b0, ct, lat, dn, st, to, tv);
    n_checks++;
    if (ct !== exp_v[0] || to) begin n_fail++; $display("FAIL enable_ct: got %h expected %h", ct, exp_v[0]); end
    n_checks++;
    if (lat !== 16) begin n_fail++; $display("FAIL enable_latency: got %0d expected 16", lat); end
  endtask

  task automatic test_clear();
    logic [127:0] ct; int lat, dn, st; bit to, tv;
    pulse_clear();
    run_block(pt_v[0], key_v, 0, 1'b0, ct, lat, dn, st, to, tv);
    pulse_clear();
    run_block(pt_v[0], key_v, 0, 1'b0, ct, lat, dn, st, to, tv);
    n_checks++;
    if (ct !== exp_v[0] || to) begin n_fail++; $display("FAIL clear_ct: got %h expected %h", ct, exp_v[0]); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] ct; int lat, dn, st; bit to, tv, saw_out, saw_busy;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_valid = 1'b1; a_data = pt_v[1][(3 - i) * 32 +: 32];
      b_valid = 1'b1; b_data = key_v[(3 - i) * 32 +: 32];
    end
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (flags.busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b expected 1", flags.busy); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    saw_out = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (d_valid) saw_out = 1'b1;
      if (flags.busy) saw_busy = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (saw_out !== 1'b0 || saw_busy !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_quiet: got valid=%b busy=%b expected 0 0", saw_out, saw_busy);
    end
    run_block(pt_v[0], key_v, 0, 1'b0, ct, lat, dn, st, to, tv);
    n_checks++;
    if (ct !== exp_v[0] || to) begin n_fail++; $display("FAIL mid_rst_ct: got %h expected %h", ct, exp_v[0]); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    key_v = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    pt_v[0] = 128'h6bc1bee22e409f96e93d7e117393172a;
    pt_v[1] = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    pt_v[2] = 128'h30c81c46a35ce411e5fbc1191a0a52ef;
    pt_v[3] = 128'hf69f2445df4f9b17ad2b417be66c3710;
`ifdef AES_CBC_ENGINE_CBC_EN
    exp_v[0] = 128'h7649abac8119b246cee98e9b12e9197d;
    exp_v[1] = 128'h5086cb9b507219ee95db113a917678b2;
    exp_v[2] = 128'h73bed6b8e3c1743b7116e69e22229516;
    exp_v[3] = 128'h3ff1caa1681fac09120eca307586e1a7;
`else
    exp_v[0] = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    exp_v[1] = 128'hf5d3d58503b9699de785895a96fdbaaf;
    exp_v[2] = 128'h43b1cd7f598ece23881b00e3ed030688;
    exp_v[3] = 128'h7b0c785e27e8ad3f8223207104725dd4;
`endif
    test_reset();
    test_cbc_block1();
    test_chain();
    test_backpressure();
    test_input_order();
    test_enable();
    test_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
